// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is shared across all bit positions, and the borrow is held in a flop.

module serial_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ br;
  assign bo = (~x & y) | (~(x ^ y) & br);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, wr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             amsb, bmsb;
  logic             accept, last, d, bo;
  logic [WIDTH-1:0] wr_nxt;

  // A start request is taken in IDLE or DONE. While in RUN it is ignored.
  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign wr_nxt = {d, wr[WIDTH-1:1]};

  serial_subtractor_cell u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .br (br),
    .d  (d),
    .bo (bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      wr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      br   <= bin;
      cnt  <= '0;
      amsb <= a[WIDTH-1];
      bmsb <= b[WIDTH-1];
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      wr <= wr_nxt;
      br <= bo;
      // Hold on the last bit so the counter never wraps inside an operation.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        diff <= wr_nxt;
        bout <= bo;
        // The final d is the result MSB.
        ovf  <= (amsb != bmsb) && (d != amsb);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor: directed WIDTH=8 cases, then an exhaustive WIDTH=4 sweep.

module tb_serial_subtractor;
  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4, ovf4;
  logic [3:0] a4, b4, diff4;

  exp_t q8[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic with signed range check.
  function automatic exp_t model(input int w, input int a, input int b, input int bi);
    exp_t e;
    int m, r, sa, sb, sr;
    m  = 1 << w;
    r  = a - b - bi;
    e.diff = 8'((r + m) % m);
    e.bout = (r < 0);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sa - sb - bi;
    e.ovf = (sr < -(m / 2)) || (sr > m / 2 - 1);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) chk("spurious done8", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e.diff));
        chk("bout8", 32'(bout8), 32'(e.bout));
        chk("ovf8",  32'(ovf8),  32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) chk("spurious done4", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(e.diff[3:0]));
        chk("bout4", 32'(bout4), 32'(e.bout));
        chk("ovf4",  32'(ovf4),  32'(e.ovf));
      end
    end
  end

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("timeout8", 32'd0, 32'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      output int lat, output int bc);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    q8.push_back(model(8, int'(a), int'(b), int'(bi)));
    lat = 0; bc = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      if (busy8) bc++;
    end while (!done8 && lat < 30);
    if (!done8) chk("timeout8", 32'd0, 32'd1);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    q4.push_back(model(4, int'(a), int'(b), int'(bi)));
    n = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      n++;
    end while (!done4 && n < 20);
    if (!done4) chk("timeout4", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, bc, n;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy8), 32'd0);
    chk("rst done", 32'(done8), 32'd0);
    chk("rst diff", 32'(diff8), 32'd0);
    chk("rst bout", 32'(bout8), 32'd0);
    chk("rst ovf",  32'(ovf8),  32'd0);
    rst = 1'b0;

    run8(8'd100, 8'd37, 1'b0, lat, bc);
    chk("basic latency", 32'(lat), 32'd9);
    chk("basic busy cycles", 32'(bc), 32'd8);
    chk("basic diff", 32'(diff8), 32'd63);

    run8(8'd5, 8'd10, 1'b0, lat, bc);
    chk("underflow diff", 32'(diff8), 32'hFB);
    chk("underflow bout", 32'(bout8), 32'd1);
    run8(8'h80, 8'h01, 1'b0, lat, bc);
    chk("sovf1 diff", 32'(diff8), 32'h7F);
    chk("sovf1 ovf", 32'(ovf8), 32'd1);
    run8(8'h00, 8'h00, 1'b1, lat, bc);
    chk("bin1 diff", 32'(diff8), 32'hFF);
    chk("bin1 bout", 32'(bout8), 32'd1);
    run8(8'h10, 8'h0F, 1'b1, lat, bc);
    chk("bin2 diff", 32'(diff8), 32'h00);
    chk("bin2 bout", 32'(bout8), 32'd0);

    // A start pulse during RUN must be dropped without disturbing the result.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd37; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(8, 100, 37, 0));
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    wait_done8();
    chk("drop diff", 32'(diff8), 32'd63);
    repeat (3) @(negedge clk);
    chk("drop idle", 32'(busy8), 32'd0);

    // Back-to-back: start held through the DONE cycle.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd10; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(8, 5, 10, 0));
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd4;
    q8.push_back(model(8, 9, 4, 0));
    wait_done8();
    chk("b2b first diff", 32'(diff8), 32'hFB);
    @(negedge clk); start8 = 1'b0;
    chk("b2b no idle", 32'(busy8), 32'd1);
    chk("b2b diff hold", 32'(diff8), 32'hFB);
    n = 1;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b latency", 32'(n), 32'd9);
    chk("b2b diff", 32'(diff8), 32'd5);

    run8(8'h7F, 8'hFF, 1'b0, lat, bc);
    chk("sovf2 diff", 32'(diff8), 32'h80);
    chk("sovf2 ovf", 32'(ovf8), 32'd1);
    chk("sovf2 bout", 32'(bout8), 32'd1);

    // Reset 4 cycles into RUN: outputs clear at once and no done follows.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd50; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(8, 200, 50, 0));
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    q8.delete();
    #1;
    chk("mid-rst busy", 32'(busy8), 32'd0);
    chk("mid-rst done", 32'(done8), 32'd0);
    chk("mid-rst diff", 32'(diff8), 32'd0);
    chk("mid-rst bout", 32'(bout8), 32'd0);
    chk("mid-rst ovf",  32'(ovf8),  32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("post-rst idle", 32'(busy8), 32'd0);
    run8(8'd100, 8'd37, 1'b0, lat, bc);
    chk("post-rst latency", 32'(lat), 32'd9);
    chk("post-rst diff", 32'(diff8), 32'd63);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run4(4'(ia), 4'(ib), 1'(ic));

    repeat (3) @(negedge clk);
    chk("q8 drained", 32'(q8.size()), 32'd0);
    chk("q4 drained", 32'(q4.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
